uart_rx_ctrl: RTL and testbench

Receive-side controller between `uart_rx` and the terminal core. It watches the receiver's data-valid level, captures each byte into a local FIFO, and pulses the receiver's "next" input to release it for the following frame. It presents the buffered bytes to the consumer over a valid/ready handshake and keeps a sticky overflow flag. This decouples the terminal logic from UART frame timing, so the receiver's hold-until-acknowledged behaviour never stalls the consumer.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_byte_fifo.sv | 59 +++++
 rtl/uart_rx_ctrl.sv | 90 +++++++++
 tb/tb_uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller.
package uart_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_CLR = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Push,
    input  logic [7:0]               i_Data,
    input  logic                     i_Pop,
    output logic [7:0]               o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign o_Full  = (o_Count == CW'(DEPTH));
    assign o_Empty = (o_Count == '0);
    assign push_ok = i_Push && !o_Full;
    assign pop_ok  = i_Pop && !o_Empty;
    assign o_Data  = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    // Pointers wrap at the power-of-two depth; count never exceeds DEPTH
    // because pushes are refused when full.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                o_Count <= o_Count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                o_Count <= o_Count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Captures bytes from uart_rx into a local FIFO, acknowledges each frame,
// and offers buffered bytes to the consumer over valid/ready.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter bit          HOLD_WHEN_FULL = 1'b0
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_Rx_DV,
    input  logic [7:0]                     i_Rx_Byte,
    output logic                           o_Rx_Next,
    output logic                           o_Valid,
    output logic [7:0]                     o_Data,
    input  logic                           i_Ready,
    output logic [$clog2(FIFO_DEPTH):0]    o_Count,
    output logic                           o_Overflow,
    input  logic                           i_Clear_Overflow
);

    rx_state_t state;
    logic      fifo_full;
    logic      fifo_empty;
    logic      detect;
    logic      push;
    logic      drop;
    logic      pop;

    // Full is judged on pre-pop occupancy, so a same-cycle pop never frees room.
    always_comb begin
        detect = (state == S_IDLE) && i_Rx_DV;
        push   = detect && !fifo_full;
        drop   = detect && fifo_full && !HOLD_WHEN_FULL;
        pop    = !fifo_empty && i_Ready;
    end

    assign o_Valid = !fifo_empty;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (push),
        .i_Data  (i_Rx_Byte),
        .i_Pop   (pop),
        .o_Data  (o_Data),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty),
        .o_Count (o_Count)
    );

    // o_Rx_Next is registered alongside the state so it is high exactly in S_ACK.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            o_Rx_Next  <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            o_Rx_Next <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (push || drop) begin
                        state     <= S_ACK;
                        o_Rx_Next <= 1'b1;
                    end
                end
                S_ACK: begin
                    state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    if (!i_Rx_DV) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (drop) begin
                o_Overflow <= 1'b1;
            end else if (i_Clear_Overflow) begin
                o_Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drop-on-full instance (dut0) and hold-on-full instance (dut1).
module tb_uart_rx_ctrl;

    logic       clk;
    logic [1:0] rst;
    logic [1:0] rx_dv;
    logic [7:0] rx_byte [2];
    logic [1:0] rdy;
    logic [1:0] clr;
    logic [1:0] rx_next;
    logic [1:0] valid;
    logic [7:0] data [2];
    logic [4:0] count [2];
    logic [1:0] ovf;

    int checks = 0;
    int passes = 0;
    int ack0   = 0;
    int ack1   = 0;
    logic [1:0] prev_next;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    uart_rx_ctrl #(.FIFO_DEPTH(16), .HOLD_WHEN_FULL(1'b0)) dut0 (
        .i_Clock(clk), .i_Reset(rst[0]), .i_Rx_DV(rx_dv[0]), .i_Rx_Byte(rx_byte[0]),
        .o_Rx_Next(rx_next[0]), .o_Valid(valid[0]), .o_Data(data[0]), .i_Ready(rdy[0]),
        .o_Count(count[0]), .o_Overflow(ovf[0]), .i_Clear_Overflow(clr[0])
    );

    uart_rx_ctrl #(.FIFO_DEPTH(16), .HOLD_WHEN_FULL(1'b1)) dut1 (
        .i_Clock(clk), .i_Reset(rst[1]), .i_Rx_DV(rx_dv[1]), .i_Rx_Byte(rx_byte[1]),
        .o_Rx_Next(rx_next[1]), .o_Valid(valid[1]), .o_Data(data[1]), .i_Ready(rdy[1]),
        .o_Count(count[1]), .o_Overflow(ovf[1]), .i_Clear_Overflow(clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer-side scoreboard and ack-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst[0]) begin
            if (valid[0] && rdy[0]) begin
                exp = (q0.size() > 0) ? {1'b0, q0.pop_front()} : 9'h100;
                chk("sb0_data", 32'({1'b0, data[0]}), 32'(exp));
            end
            if (rx_next[0]) begin
                chk("ack0_width", 32'(prev_next[0]), 32'd0);
                ack0++;
            end
        end
        if (!rst[1]) begin
            if (valid[1] && rdy[1]) begin
                exp = (q1.size() > 0) ? {1'b0, q1.pop_front()} : 9'h100;
                chk("sb1_data", 32'({1'b0, data[1]}), 32'(exp));
            end
            if (rx_next[1]) begin
                chk("ack1_width", 32'(prev_next[1]), 32'd0);
                ack1++;
            end
        end
        prev_next = rx_next;
    end

    // Receiver model: DV high until ack, then two more cycles (+extra), then low.
    task automatic send(input int d, input logic [7:0] b, input int extra,
                        input bit keep, input bit clr_at_detect);
        bit got;
        rx_dv[d]   = 1'b1;
        rx_byte[d] = b;
        clr[d]     = clr_at_detect;
        if (keep) begin
            if (d == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            clr[d] = 1'b0;
            if (rx_next[d]) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        repeat (2 + extra) tick();
        rx_dv[d] = 1'b0;
        tick();
    endtask

    task automatic drain(input int d);
        rdy[d] = 1'b1;
        for (int i = 0; i < 40 && count[d] != 0; i++) tick();
        rdy[d] = 1'b0;
        chk("drain_empty", 32'(count[d]), 32'd0);
    endtask

    initial begin
        int a;
        rst = 2'b11; rx_dv = '0; rdy = '0; clr = '0;
        rx_byte[0] = '0; rx_byte[1] = '0;
        prev_next = '0;
        repeat (2) tick();
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_count", 32'(count[0]), 32'd0);
        chk("rst_ovf",   32'(ovf[0]),   32'd0);
        chk("rst_next",  32'(rx_next[0]), 32'd0);
        rst = 2'b00;
        tick();

        // Two bytes straight through with the consumer ready.
        rdy[0] = 1'b1;
        send(0, 8'h41, 0, 1'b1, 1'b0);
        send(0, 8'h42, 0, 1'b1, 1'b0);
        tick();
        rdy[0] = 1'b0;
        chk("t1_acks",  32'(ack0), 32'd2);
        chk("t1_ovf",   32'(ovf[0]), 32'd0);
        chk("t1_count", 32'(count[0]), 32'd0);

        // DV held long after the ack: single capture.
        a = ack0;
        send(0, 8'h55, 3, 1'b1, 1'b0);
        chk("t2_count", 32'(count[0]), 32'd1);
        chk("t2_acks",  32'(ack0 - a), 32'd1);
        drain(0);

        // Fill to 16, then 17th is acknowledged but dropped.
        a = ack0;
        for (int i = 0; i < 17; i++) send(0, 8'(i * 7 + 3), 0, i < 16, 1'b0);
        chk("t3_count", 32'(count[0]), 32'd16);
        chk("t3_ovf",   32'(ovf[0]), 32'd1);
        chk("t3_acks",  32'(ack0 - a), 32'd17);
        chk("t3_head",  32'(data[0]), 32'h03);

        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("clr_ovf", 32'(ovf[0]), 32'd0);
        send(0, 8'hEE, 0, 1'b0, 1'b1);
        chk("set_wins", 32'(ovf[0]), 32'd1);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("clr_ovf2", 32'(ovf[0]), 32'd0);

        // Full with a same-cycle pop: byte still dropped.
        rdy[0] = 1'b1; rx_dv[0] = 1'b1; rx_byte[0] = 8'h99;
        tick();
        rdy[0] = 1'b0;
        chk("fp_next",  32'(rx_next[0]), 32'd1);
        chk("fp_count", 32'(count[0]), 32'd15);
        chk("fp_ovf",   32'(ovf[0]), 32'd1);
        repeat (2) tick();
        rx_dv[0] = 1'b0;
        tick();
        drain(0);

        // Hold-when-full: no ack while full, push right after a pop.
        for (int i = 0; i < 16; i++) send(1, 8'(8'hB0 + i), 0, 1'b1, 1'b0);
        chk("h_count", 32'(count[1]), 32'd16);
        a = ack1;
        rx_dv[1] = 1'b1; rx_byte[1] = 8'hA5; q1.push_back(8'hA5);
        repeat (5) tick();
        chk("h_no_ack",  32'(ack1 - a), 32'd0);
        chk("h_count2",  32'(count[1]), 32'd16);
        rdy[1] = 1'b1;
        tick();
        rdy[1] = 1'b0;
        chk("h_pop_next",  32'(rx_next[1]), 32'd0);
        chk("h_pop_count", 32'(count[1]), 32'd15);
        tick();
        chk("h_push_next",  32'(rx_next[1]), 32'd1);
        chk("h_push_count", 32'(count[1]), 32'd16);
        repeat (2) tick();
        rx_dv[1] = 1'b0;
        tick();
        chk("h_ovf", 32'(ovf[1]), 32'd0);
        drain(1);

        // Reset while in S_WAIT_CLR with 5 bytes buffered and overflow set.
        for (int i = 0; i < 4; i++) send(0, 8'(8'hC0 + i), 0, 1'b1, 1'b0);
        rx_dv[0] = 1'b1; rx_byte[0] = 8'hC4;
        repeat (2) tick();
        chk("r_pre_count", 32'(count[0]), 32'd5);
        chk("r_pre_ovf",   32'(ovf[0]), 32'd1);
        rst[0] = 1'b1; q0.delete();
        tick();
        chk("r_count", 32'(count[0]), 32'd0);
        chk("r_valid", 32'(valid[0]), 32'd0);
        chk("r_ovf",   32'(ovf[0]), 32'd0);
        chk("r_next",  32'(rx_next[0]), 32'd0);
        rst[0] = 1'b0; q0.push_back(8'hC4);
        tick();
        chk("r_recap_next",  32'(rx_next[0]), 32'd1);
        chk("r_recap_count", 32'(count[0]), 32'd1);
        repeat (2) tick();
        rx_dv[0] = 1'b0;
        tick();
        drain(0);

        tick();
        chk("sb0_left", 32'(q0.size()), 32'd0);
        chk("sb1_left", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
